// File: rtl/shreg_seq_ctrl_if.sv
// Command/response bundle between a requester and the shift-register sequencer.
interface shreg_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] rd_data;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rd_data, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rd_data, done, err
    );
endinterface

// File: rtl/shreg_seq_ctrl.sv
// Sequencer for a serial-in/parallel-out chain: serial LOAD (MSB first), CLEAR and PRESET
// commands, with capture of the chain's parallel output on completion.
module shreg_seq_ctrl #(
    parameter int WIDTH     = 4,
    parameter int SHIFT_DIV = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    shreg_seq_ctrl_if.slave   cmd,
    output logic              sr_d_o,
    output logic              sr_en_o,
    output logic              sr_clr_o,
    output logic              sr_set_o,
    input  logic [WIDTH-1:0]  sr_q_i,
    output logic              busy_o
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_CLR   = 3'd2;
    localparam logic [2:0] ST_SET   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [WIDTH-1:0] word_q,    word_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             err_q,     err_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             step_end_s;

    assign step_end_s = (div_cnt_q == DIV_LAST);

    // Next-state logic for the command FSM and its word/counter registers.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    word_d    = cmd.cmd_data;
                    err_d     = (cmd.cmd_op == 2'b11);
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    case (cmd.cmd_op)
                        2'b00:   state_d = ST_SHIFT;
                        2'b01:   state_d = ST_CLR;
                        2'b10:   state_d = ST_SET;
                        default: state_d = ST_FIN;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The word shifts left so its MSB always presents the bit of the current step.
                if (step_end_s) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    word_d    = {word_q[WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            ST_CLR:  state_d = ST_FIN;
            ST_SET:  state_d = ST_FIN;
            ST_FIN: begin
                rd_data_d = sr_q_i;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Outputs decode the registered state; rst forces every strobe low immediately.
    assign cmd.cmd_ready = (state_q == ST_IDLE) & ~rst_i;
    assign cmd.done      = (state_q == ST_FIN) & ~rst_i;
    assign cmd.err       = (state_q == ST_FIN) & err_q & ~rst_i;
    assign cmd.rd_data   = rd_data_q;
    assign sr_en_o       = (state_q == ST_SHIFT) & step_end_s & ~rst_i;
    assign sr_d_o        = (state_q == ST_SHIFT) & word_q[WIDTH-1] & ~rst_i;
    assign sr_clr_o      = (state_q == ST_CLR) & ~rst_i;
    assign sr_set_o      = (state_q == ST_SET) & ~rst_i;
    assign busy_o        = (state_q != ST_IDLE) & ~rst_i;
endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Directed bench: two sequencers (SHIFT_DIV=1 and 3) each driving a behavioural chain model.
module tb_shreg_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] op = 2'b00;
    logic [3:0] data = 4'h0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    shreg_seq_ctrl_if #(.WIDTH(4)) ifa ();
    shreg_seq_ctrl_if #(.WIDTH(4)) ifb ();

    logic a_d, a_en, a_clr, a_set, a_busy;
    logic b_d, b_en, b_clr, b_set, b_busy;
    logic [3:0] qa = 4'h0;
    logic [3:0] qb = 4'h0;

    assign ifa.cmd_valid = valid & ~sel;
    assign ifa.cmd_op    = op;
    assign ifa.cmd_data  = data;
    assign ifb.cmd_valid = valid & sel;
    assign ifb.cmd_op    = op;
    assign ifb.cmd_data  = data;

    shreg_seq_ctrl #(.WIDTH(4), .SHIFT_DIV(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .cmd(ifa),
        .sr_d_o(a_d), .sr_en_o(a_en), .sr_clr_o(a_clr), .sr_set_o(a_set),
        .sr_q_i(qa), .busy_o(a_busy)
    );

    shreg_seq_ctrl #(.WIDTH(4), .SHIFT_DIV(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .cmd(ifb),
        .sr_d_o(b_d), .sr_en_o(b_en), .sr_clr_o(b_clr), .sr_set_o(b_set),
        .sr_q_i(qb), .busy_o(b_busy)
    );

    // Chain models: d -> q[0] -> ... -> q[3].
    always @(posedge clk) begin
        if (a_clr) qa <= 4'h0;
        else if (a_set) qa <= 4'hF;
        else if (a_en) qa <= {qa[2:0], a_d};
        if (b_clr) qb <= 4'h0;
        else if (b_set) qb <= 4'hF;
        else if (b_en) qb <= {qb[2:0], b_d};
    end

    logic       o_d, o_en, o_clr, o_set, o_busy, o_ready, o_done, o_err;
    logic [3:0] o_rd;
    assign o_d     = sel ? b_d : a_d;
    assign o_en    = sel ? b_en : a_en;
    assign o_clr   = sel ? b_clr : a_clr;
    assign o_set   = sel ? b_set : a_set;
    assign o_busy  = sel ? b_busy : a_busy;
    assign o_ready = sel ? ifb.cmd_ready : ifa.cmd_ready;
    assign o_done  = sel ? ifb.done : ifa.done;
    assign o_err   = sel ? ifb.err : ifa.err;
    assign o_rd    = sel ? ifb.rd_data : ifa.rd_data;

    typedef struct {
        logic       s;
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] rd;
        logic       err;
        int         lat;
        int         en;
        int         clr;
        int         set;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Starts just after the accept edge; monitors cycle by cycle until done.
    task automatic watch(input logic [3:0] word, input int div, input bit is_load,
                         output int lat, output int n_en, output int n_clr, output int n_set,
                         output int viol, output logic e);
        int exp_bit;
        lat = 0; n_en = 0; n_clr = 0; n_set = 0; viol = 0; e = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (o_en) begin
                n_en++;
                if (c % div != 0) viol++;
            end
            n_clr += int'(o_clr);
            n_set += int'(o_set);
            if (int'(o_en) + int'(o_clr) + int'(o_set) > 1) viol++;
            if (o_ready || !o_busy) viol++;
            if (is_load && c <= 4 * div) begin
                exp_bit = int'(word[3 - (c - 1) / div]);
                if (int'(o_d) != exp_bit) viol++;
            end else if (o_d) begin
                viol++;
            end
            if (o_done) begin
                lat = c;
                e = o_err;
                break;
            end
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        #1;
        while (!o_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!o_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic run_vec(input int i);
        int lat, n_en, n_clr, n_set, viol;
        logic e;
        sel = vt[i].s; op = vt[i].op; data = vt[i].data; valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        valid = 1'b0; data = ~vt[i].data; op = 2'b11;
        watch(vt[i].data, vt[i].s ? 3 : 1, vt[i].op == 2'b00, lat, n_en, n_clr, n_set, viol, e);
        chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
        chk($sformatf("v%0d_err", i), int'(e), int'(vt[i].err));
        chk($sformatf("v%0d_en", i), n_en, vt[i].en);
        chk($sformatf("v%0d_clr", i), n_clr, vt[i].clr);
        chk($sformatf("v%0d_set", i), n_set, vt[i].set);
        chk($sformatf("v%0d_viol", i), viol, 0);
        @(negedge clk);
        chk($sformatf("v%0d_rd", i), int'(o_rd), int'(vt[i].rd));
        chk($sformatf("v%0d_ready", i), int'(o_ready), 1);
    endtask

    initial begin
        int lat, n_en, n_clr, n_set, viol;
        logic e;
        //       s     op     data   rd     err   lat en clr set
        vt[0]  = '{1'b0, 2'b00, 4'hB, 4'hB, 1'b0, 5,  4, 0, 0};
        vt[1]  = '{1'b0, 2'b10, 4'h0, 4'hF, 1'b0, 2,  0, 0, 1};
        vt[2]  = '{1'b0, 2'b01, 4'h5, 4'h0, 1'b0, 2,  0, 1, 0};
        vt[3]  = '{1'b0, 2'b00, 4'h6, 4'h6, 1'b0, 5,  4, 0, 0};
        vt[4]  = '{1'b0, 2'b11, 4'hA, 4'h6, 1'b1, 1,  0, 0, 0};
        vt[5]  = '{1'b0, 2'b00, 4'h8, 4'h8, 1'b0, 5,  4, 0, 0};
        vt[6]  = '{1'b0, 2'b00, 4'h1, 4'h1, 1'b0, 5,  4, 0, 0};
        vt[7]  = '{1'b0, 2'b11, 4'hF, 4'h1, 1'b1, 1,  0, 0, 0};
        vt[8]  = '{1'b0, 2'b10, 4'h3, 4'hF, 1'b0, 2,  0, 0, 1};
        vt[9]  = '{1'b1, 2'b00, 4'h6, 4'h6, 1'b0, 13, 4, 0, 0};
        vt[10] = '{1'b1, 2'b11, 4'h2, 4'h6, 1'b1, 1,  0, 0, 0};
        vt[11] = '{1'b1, 2'b00, 4'h9, 4'h9, 1'b0, 13, 4, 0, 0};

        // Reset with a pending command: rst must win.
        valid = 1'b1; op = 2'b00; data = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a", int'(ifa.cmd_ready), 0);
        chk("rst_busy_a", int'(a_busy), 0);
        chk("rst_strobes_a", int'({a_d, a_en, a_clr, a_set, ifa.done, ifa.err}), 0);
        chk("rst_rd_a", int'(ifa.rd_data), 0);
        chk("rst_rd_b", int'(ifb.rd_data), 0);
        chk("rst_outs_b", int'({b_d, b_en, b_clr, b_set, b_busy, ifb.cmd_ready, ifb.done}), 0);
        @(posedge clk); #1;
        valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(ifa.cmd_ready), 1);
        chk("post_rst_busy", int'(a_busy), 0);

        for (int i = 0; i < 12; i++) run_vec(i);

        // Held cmd_valid with a new word during a LOAD.
        sel = 1'b0; op = 2'b00; data = 4'hB; valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        data = 4'h5;
        watch(4'hB, 1, 1'b1, lat, n_en, n_clr, n_set, viol, e);
        chk("hold_lat1", lat, 5);
        chk("hold_viol1", viol, 0);
        @(negedge clk);
        chk("hold_ready", int'(o_ready), 1);
        chk("hold_rd1", int'(o_rd), 11);
        @(posedge clk); #1;
        valid = 1'b0;
        watch(4'h5, 1, 1'b1, lat, n_en, n_clr, n_set, viol, e);
        chk("hold_lat2", lat, 5);
        chk("hold_en2", n_en, 4);
        chk("hold_viol2", viol, 0);
        @(negedge clk);
        chk("hold_rd2", int'(o_rd), 5);

        // rst in step 2 of a LOAD.
        op = 2'b00; data = 4'hD; valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        chk("abort_step1_en", int'(o_en), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_en_rst", int'(o_en), 0);
        chk("abort_done_rst", int'(o_done), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_en_next", int'(o_en), 0);
        chk("abort_busy_next", int'(o_busy), 0);
        chk("abort_done_next", int'(o_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", int'(o_ready), 1);
        chk("abort_done_after", int'(o_done), 0);
        chk("abort_rd", int'(o_rd), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
